// File: rtl/uart_frame_tx_arb.sv
// Four-requester frame arbiter feeding a byte-wide UART transmitter: each frame is
// 3 payload bytes (MSB first) + 3 x 8'hFF. Define UART_ARB_FIXED_PRIO_EN for fixed priority.
module uart_frame_tx_arb #(
    parameter logic [15:0] IDLE_GAP = 16'd0
) (
    input  logic        clk_100M,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [95:0] req_data,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        busy,
    output logic [1:0]  cur_id
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]  state;
    logic [2:0]  idx;
    logic [23:0] payload;
    logic [15:0] gap_cnt;
    logic [1:0]  winner;
    logic [23:0] req_payload [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_payload
            assign req_payload[gi] = req_data[24*gi+23 : 24*gi];
        end
    endgenerate

`ifdef UART_ARB_FIXED_PRIO_EN
    // Lowest index wins: scan downward so the last hit is the highest priority.
    always_comb begin
        winner = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) winner = k[1:0];
        end
    end
`else
    logic [1:0] last_owner;
    logic [1:0] cand;
    logic       found;

    // Search starts one past the previous owner; k = 4 wraps back to the owner itself.
    always_comb begin
        winner = last_owner;
        cand   = 2'd0;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_owner + k[1:0];
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= 3'd0;
            payload <= 24'h0;
            gap_cnt <= 16'd0;
            gnt     <= 4'b0;
            done    <= 4'b0;
            cur_id  <= 2'd0;
`ifndef UART_ARB_FIXED_PRIO_EN
            last_owner <= 2'd3;
`endif
        end else begin
            gnt  <= 4'b0;
            done <= 4'b0;
            case (state)
                ST_IDLE: begin
                    if (req != 4'b0) begin
                        payload <= req_payload[winner];
                        cur_id  <= winner;
                        gnt     <= 4'(4'b0001 << winner);
                        idx     <= 3'd0;
                        state   <= ST_SEND;
`ifndef UART_ARB_FIXED_PRIO_EN
                        last_owner <= winner;
`endif
                    end
                end
                ST_SEND: begin
                    if (byte_ready) begin
                        if (idx == 3'd5) begin
                            done <= 4'(4'b0001 << cur_id);
                            idx  <= 3'd0;
                            if (IDLE_GAP != 16'd0) begin
                                state   <= ST_GAP;
                                gap_cnt <= 16'd0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == IDLE_GAP - 16'd1) begin
                        gap_cnt <= 16'd0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign byte_valid = (state == ST_SEND);
    assign busy       = (state != ST_IDLE);

    // Outside SEND the byte lane is forced to zero so the idle bus is quiet.
    always_comb begin
        byte_data = 8'h00;
        if (state == ST_SEND) begin
            case (idx)
                3'd0:    byte_data = payload[23:16];
                3'd1:    byte_data = payload[15:8];
                3'd2:    byte_data = payload[7:0];
                default: byte_data = 8'hFF;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx_arb.sv
// Bench for uart_frame_tx_arb: transaction-level model (arbitration order, frame bytes,
// done timing, stall stability) plus directed scenarios with literal expectations.
module tb_uart_frame_tx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req5;
    logic [95:0] req_data;
    logic        byte_ready, byte_ready5;
    logic [7:0]  bd, bd5;
    logic        bv, bv5, busy, busy5;
    logic [3:0]  gnt, gnt5, done, done5;
    logic [1:0]  cur_id, cid5;

    always #5 clk = ~clk;

    uart_frame_tx_arb #(.IDLE_GAP(16'd0)) dut (
        .clk_100M(clk), .rst(rst), .req(req), .req_data(req_data),
        .byte_ready(byte_ready), .byte_data(bd), .byte_valid(bv),
        .gnt(gnt), .done(done), .busy(busy), .cur_id(cur_id));

    uart_frame_tx_arb #(.IDLE_GAP(16'd5)) dut5 (
        .clk_100M(clk), .rst(rst), .req(req5), .req_data(req_data),
        .byte_ready(byte_ready5), .byte_data(bd5), .byte_valid(bv5),
        .gnt(gnt5), .done(done5), .busy(busy5), .cur_id(cid5));

    int tests = 0;
    int fails = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Spec-level arbitration rule.
    function automatic int pick(int last, logic [3:0] r);
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
        return -1;
    endfunction

    // ---------------- model / monitor ----------------
    int          m_last = 3;
    int          m_owner = 0;
    int          mw;
    logic [23:0] mpl;
    logic [7:0]  exp_q[$];
    bit          expect_done = 0;
    logic [3:0]  p_req = 0;
    logic [95:0] p_data = 0;
    bit          p_valid = 0, p_ready = 0;
    logic [7:0]  p_bdata = 0;
    int          gnt_log[$];
    logic [7:0]  byte_log[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_byte_valid", bv, 0);
            check("rst_byte_data", bd, 0);
            check("rst_gnt", gnt, 0);
            check("rst_done", done, 0);
            check("rst_busy", busy, 0);
            check("rst_cur_id", cur_id, 0);
            exp_q.delete();
            m_last = 3;
            expect_done = 0;
            p_valid = 0; p_ready = 0; p_req = 0;
        end else begin
            check("gnt_onehot", $countones(gnt) <= 1, 1);
            check("done_onehot", $countones(done) <= 1, 1);
            if (expect_done) begin
                check("done_pulse", done, 32'(1 << m_owner));
                check("valid_low_after_last", bv, 0);
                done_cnt++;
            end else begin
                check("done_idle", done, 0);
            end
            expect_done = 0;
            if (p_valid && !p_ready) begin
                check("stall_valid", bv, 1);
                check("stall_data", bd, p_bdata);
            end
            if (gnt != 4'b0) begin
                mw = pick(m_last, p_req);
                check("gnt_winner", gnt, (mw < 0) ? 32'h0 : 32'(1 << mw));
                check("gnt_first_valid", bv, 1);
                check("gnt_no_frame_open", exp_q.size(), 0);
                if (mw >= 0) begin
                    m_last = mw;
                    m_owner = mw;
                    gnt_log.push_back(mw);
                    mpl = p_data[24*mw +: 24];
                    exp_q = '{mpl[23:16], mpl[15:8], mpl[7:0], 8'hFF, 8'hFF, 8'hFF};
                end
            end
            if (bv) begin
                check("cur_id", cur_id, m_owner);
                check("busy", busy, 1);
            end
            if (bv && byte_ready) begin
                check("byte_in_frame", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("byte_data", bd, exp_q.pop_front());
                    byte_log.push_back(bd);
                    if (exp_q.size() == 0) expect_done = 1;
                end
            end
            p_req = req; p_data = req_data;
            p_valid = bv; p_ready = byte_ready; p_bdata = bd;
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] hold = 0, hold5 = 0;
    bit         pat_en = 0;
    logic [3:0] pat = 4'b1001;    // bit k = byte_ready on cycle k: 1,0,0,1
    int         pcnt = 0;
    bit         v5[$];

    task automatic cyc();
        @(posedge clk);
        #1;
        if (pat_en) begin
            byte_ready = pat[pcnt % 4];
            pcnt++;
        end
        req  = req  & ~(gnt  & ~hold);
        req5 = req5 & ~(gnt5 & ~hold5);
        v5.push_back(bv5);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 0; req5 = 0; hold = 0; hold5 = 0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic wait_done(int target, int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) cyc();
        check("frames_done", done_cnt, target);
    endtask

    function automatic logic [7:0] blog(int i);
        return (i < byte_log.size()) ? byte_log[i] : 8'hxx;
    endfunction

    function automatic int glog(int i);
        return (i < gnt_log.size()) ? gnt_log[i] : -1;
    endfunction

    int          gb, bb, db, first, ones, zeros, ones2, k;
    logic [7:0]  frame_a [6];
    logic [7:0]  frame_b [6];
    int          rr_exp  [5];
    int          mix_exp [3];

    initial begin
        frame_a = '{8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF, 8'hFF};
        frame_b = '{8'hA5, 8'hA5, 8'hA5, 8'hFF, 8'hFF, 8'hFF};
        rr_exp  = '{0, 1, 2, 3, 0};
`ifdef UART_ARB_FIXED_PRIO_EN
        mix_exp = '{0, 0, 0};
`else
        mix_exp = '{0, 3, 0};
`endif
        rst = 1'b1; req = 0; req5 = 0; req_data = 0;
        byte_ready = 1'b1; byte_ready5 = 1'b1;
        cyc(); cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Single frame from requester 1, no stalls.
        gb = gnt_log.size(); bb = byte_log.size(); db = done_cnt;
        req_data[47:24] = 24'h123456;
        req = 4'b0010;
        wait_done(db + 1, 30);
        check("t1_gnt", glog(gb), 1);
        for (int i = 0; i < 6; i++) check($sformatf("t1_byte%0d", i), blog(bb + i), frame_a[i]);
        cyc(); cyc();

        // All four held: round-robin from a fresh reset.
        do_reset();
        req_data = {24'hD00004, 24'hC00003, 24'hB00002, 24'hA00001};
        gb = gnt_log.size(); db = done_cnt;
        hold = 4'b1111; req = 4'b1111;
        wait_done(db + 5, 100);
        hold = 0; req = 0;
        for (int i = 0; i < 20; i++) cyc();
        for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), glog(gb + i), rr_exp[i]);

        // Stalled frame A5A5A5 with byte_ready pattern 1,0,0,1.
        req_data[71:48] = 24'hA5A5A5;
        gb = gnt_log.size(); bb = byte_log.size(); db = done_cnt;
        pcnt = 0; pat_en = 1;
        req = 4'b0100;
        wait_done(db + 1, 80);
        pat_en = 0; byte_ready = 1'b1;
        cyc(); cyc();
        check("t3_gnt", glog(gb), 2);
        check("t3_xfers", byte_log.size() - bb, 6);
        for (int i = 0; i < 6; i++) check($sformatf("t3_byte%0d", i), blog(bb + i), frame_b[i]);

        // IDLE_GAP = 5 instance: six idle cycles between back-to-back frames.
        v5.delete();
        hold5 = 4'b0001; req5 = 4'b0001;
        for (int i = 0; i < 40; i++) cyc();
        hold5 = 0; req5 = 0;
        for (int i = 0; i < 20; i++) cyc();
        first = -1;
        for (int i = 0; i < v5.size(); i++) if (first < 0 && v5[i]) first = i;
        ones = 0; zeros = 0; ones2 = 0;
        k = (first < 0) ? v5.size() : first;
        while (k < v5.size() && v5[k])  begin ones++;  k++; end
        while (k < v5.size() && !v5[k]) begin zeros++; k++; end
        while (k < v5.size() && v5[k])  begin ones2++; k++; end
        check("t4_frame1_len", ones, 6);
        check("t4_gap_cycles", zeros, 6);
        check("t4_frame2_len", ones2, 6);

        // Reset after byte 2 accepted: no done, pointer back to requester 0 first.
        do_reset();
        req_data[23:0] = 24'h0C0D0E;
        req_data[47:24] = 24'h111111;
        bb = byte_log.size(); db = done_cnt;
        req = 4'b0001;
        for (int i = 0; i < 20 && byte_log.size() < bb + 3; i++) cyc();
        check("t5_bytes_before_rst", byte_log.size() - bb, 3);
        rst = 1'b1;
        req = 0;
        #1;
        check("t5_valid_in_rst", bv, 0);
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc();
        check("t5_no_done", done_cnt, db);
        gb = gnt_log.size(); bb = byte_log.size();
        req = 4'b0011;
        wait_done(db + 2, 40);
        check("t5_first_gnt", glog(gb), 0);
        check("t5_restart_byte0", blog(bb), 8'h0C);
        check("t5_second_gnt", glog(gb + 1), 1);
        cyc(); cyc();

        // req=1001 held from reset.
        do_reset();
        gb = gnt_log.size(); db = done_cnt;
        hold = 4'b1001; req = 4'b1001;
        wait_done(db + 3, 60);
        hold = 0; req = 0;
        for (int i = 0; i < 12; i++) cyc();
        for (int i = 0; i < 3; i++) check($sformatf("t6_gnt%0d", i), glog(gb + i), mix_exp[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx_arb.md
UART_FRAME_TX_ARB -- requirements
Module: uart_frame_tx_arb

Interface
REQ-001 Parameter: IDLE_GAP, 16'd0, clk_100M cycles of enforced idle between consecutive frames.
REQ-002 Port: clk_100M  input  1  system clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester frame request; held high until matching gnt bit.
REQ-005 Port: req_data  input  96  requester i payload on bits [24*i+23:24*i]; valid while req[i] high.
REQ-006 Port: byte_ready  input  1  byte transmitter can accept a byte this cycle.
REQ-007 Port: byte_data  output  8  byte offered to the byte transmitter.
REQ-008 Port: byte_valid  output  1  byte_data valid; transfer on byte_valid && byte_ready at a rising edge.
REQ-009 Port: gnt  output  4  one-hot, one-cycle pulse: requester's payload captured.
REQ-010 Port: done  output  4  one-hot, one-cycle pulse: requester's frame fully handed to transmitter.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: cur_id  output  2  index of requester owning the current frame; holds last owner when idle.

Function
REQ-013 Frame format SHALL be six bytes: payload[23:16], payload[15:8], payload[7:0], 8'hFF, 8'hFF, 8'hFF, in that order.
REQ-014 States SHALL be IDLE, SEND, GAP.
REQ-015 IDLE: at an edge with req != 0, SHALL select winner, latch its 24-bit payload, set cur_id, pulse gnt[winner] next cycle, enter SEND with byte index 0.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_owner+1) mod 4, wraps past 3 to 0.
REQ-017 SEND: byte_valid SHALL be high every cycle; byte_data SHALL equal the byte at the current index (0..5).
REQ-018 byte_data SHALL remain stable while byte_valid && !byte_ready.
REQ-019 On each accepted byte, index SHALL increment; byte_ready low SHALL stall indefinitely without loss.
REQ-020 On acceptance of byte 5: byte_valid low next cycle, done[owner] pulses next cycle, state goes to GAP if IDLE_GAP != 0, else IDLE.
REQ-021 GAP: SHALL count IDLE_GAP cycles with byte_valid low, then enter IDLE; req during GAP is ignored until IDLE.
REQ-022 Back-to-back: with IDLE_GAP = 0, next frame's byte_valid SHALL rise two cycles after the last accepted byte of the previous frame (one IDLE cycle).
REQ-023 Payload changes or req deassertion after gnt SHALL NOT affect the frame in progress.
REQ-024 Requester re-asserting req the cycle done pulses SHALL be served only after other pending requesters (round-robin order).
REQ-025 gnt and done SHALL never have more than one bit set; both zero outside their pulse cycle.

Reset
REQ-026 While rst high: state IDLE, index 0, byte_valid 0, byte_data 8'h00, gnt 0, done 0, busy 0, cur_id 0, gap counter 0.
REQ-027 Round-robin pointer SHALL reset to last_owner = 3 so requester 0 has first priority.
REQ-028 Reset mid-frame SHALL abandon the frame immediately; no done pulse issued for it.

Configuration
REQ-029 Macro UART_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (req[0] highest, req[3] lowest), pointer unused; when undefined, round-robin per REQ-016.

Verification
REQ-030 req=4'b0010, payload 24'h123456, byte_ready=1 -> gnt=4'b0010, bytes 12,34,56,FF,FF,FF on six consecutive cycles, done=4'b0010 one cycle after byte 5.
REQ-031 req=4'b1111 held, IDLE_GAP=0 -> grant order 0,1,2,3,0; every frame intact.
REQ-032 byte_ready toggling 1,0,0,1,... during frame 24'hA5A5A5 -> byte_data stable during stalls, exactly six transfers, correct order.
REQ-033 IDLE_GAP=5, req=4'b0001 held -> exactly 6 cycles with byte_valid low between the two frames (5 GAP + 1 IDLE).
REQ-034 rst pulsed after byte 2 accepted -> byte_valid 0, done never pulses, next frame restarts at byte 0 serving requester 0.
REQ-035 UART_ARB_FIXED_PRIO_EN defined, req=4'b1001 held -> requester 0 granted every frame, requester 3 never.
